// File: rtl/aibnd_clkbuf_seq_pkg.sv
// Shared types and output decode for the aibnd clkbuf power/gate sequencer.
package aibnd_clkbuf_seq_pkg;

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_PWRUP   = 3'd1,
    ST_WAITRDY = 3'd2,
    ST_UNGATE  = 3'd3,
    ST_ON      = 3'd4,
    ST_DRAIN   = 3'd5,
    ST_PWRDN   = 3'd6,
    ST_FAULT   = 3'd7
  } state_t;

  // Supply/bias switch is on from power-up until drain completes.
  function automatic logic st_powered(input state_t s);
    return (s == ST_PWRUP) || (s == ST_WAITRDY) || (s == ST_UNGATE) ||
           (s == ST_ON)    || (s == ST_DRAIN);
  endfunction

  // Clock passes only once ready has been seen; always a subset of st_powered.
  function automatic logic st_gate_open(input state_t s);
    return (s == ST_UNGATE) || (s == ST_ON);
  endfunction

  function automatic logic st_busy(input state_t s);
    return (s == ST_PWRUP) || (s == ST_WAITRDY) || (s == ST_UNGATE) ||
           (s == ST_DRAIN) || (s == ST_PWRDN);
  endfunction

endpackage

// File: rtl/aibnd_clkbuf_seq_cnt.sv
// Saturating interval counter with terminal compares for settle, drain and ready timeout.
// Each terminal flag is raised on the last counted cycle so the FSM leaves on the next edge.
module aibnd_clkbuf_seq_cnt #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned SETTLE_CYC  = 16,
  parameter int unsigned DRAIN_CYC   = 8,
  parameter int unsigned TIMEOUT_CYC = 200
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_settle_done,
  output logic o_drain_done,
  output logic o_timeout
);

  localparam logic [CNT_W-1:0] L_ONE         = CNT_W'(1);
  localparam logic [CNT_W-1:0] L_SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] L_DRAIN_LAST  = CNT_W'(DRAIN_CYC - 1);
  // Counter restarts on entering WAITRDY, so the timeout budget excludes the settle time.
  localparam logic [CNT_W-1:0] L_WAIT_LAST   = CNT_W'(TIMEOUT_CYC - SETTLE_CYC - 1);

  logic [CNT_W-1:0] r_cnt;

  // Count up while enabled, clear on request, hold at all-ones.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != '1)) begin
      r_cnt <= r_cnt + L_ONE;
    end
  end

  assign o_settle_done = (r_cnt == L_SETTLE_LAST);
  assign o_drain_done  = (r_cnt == L_DRAIN_LAST);
  assign o_timeout     = (r_cnt >= L_WAIT_LAST);

endmodule

// File: rtl/aibnd_clkbuf_seq.sv
// Power/gate sequencer for the aibnd inverting clkbuf chain, clocked by the always-on clock.
// Up: power, settle, wait for ready strap, ungate. Down: gate off, drain, power off.
module aibnd_clkbuf_seq
  import aibnd_clkbuf_seq_pkg::*;
#(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned SETTLE_CYC  = 16,
  parameter int unsigned DRAIN_CYC   = 8,
  parameter int unsigned TIMEOUT_CYC = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_req,
  input  logic       buf_rdy,
  output logic       clkbuf_pwr_en,
  output logic       clkbuf_gate_en,
  output logic       en_ack,
  output logic       busy,
  output logic       err,
  output logic [2:0] state_o
);

  state_t r_state;
  state_t w_nxt;
  logic   r_pwr_en, r_gate_en, r_en_ack, r_busy, r_err;
  logic   w_pwr_en, w_gate_en, w_en_ack, w_busy, w_err;
  logic   w_cnt_clr, w_cnt_en;
  logic   w_settle_done, w_drain_done, w_timeout;

  aibnd_clkbuf_seq_cnt #(
    .CNT_W       (CNT_W),
    .SETTLE_CYC  (SETTLE_CYC),
    .DRAIN_CYC   (DRAIN_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_cnt (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_clr         (w_cnt_clr),
    .i_en          (w_cnt_en),
    .o_settle_done (w_settle_done),
    .o_drain_done  (w_drain_done),
    .o_timeout     (w_timeout)
  );

  // Next state and next registered outputs, decoded from the state being entered.
  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      ST_OFF:     if (en_req) w_nxt = ST_PWRUP;
      ST_PWRUP: begin
        if (!en_req)            w_nxt = ST_PWRDN;
        else if (w_settle_done) w_nxt = ST_WAITRDY;
      end
      ST_WAITRDY: begin
        if (!en_req)        w_nxt = ST_PWRDN;
        else if (buf_rdy)   w_nxt = ST_UNGATE;
        else if (w_timeout) w_nxt = ST_FAULT;
      end
      ST_UNGATE:  w_nxt = ST_ON;
      ST_ON:      if (!en_req) w_nxt = ST_DRAIN;
      ST_DRAIN:   if (w_drain_done) w_nxt = ST_PWRDN;
      ST_PWRDN:   w_nxt = ST_OFF;
      ST_FAULT:   if (!en_req) w_nxt = ST_OFF;
      default:    w_nxt = ST_OFF;
    endcase

    w_cnt_clr = (w_nxt != r_state);
    w_cnt_en  = (r_state == ST_PWRUP) || (r_state == ST_WAITRDY) || (r_state == ST_DRAIN);

    w_pwr_en  = st_powered(w_nxt);
    w_gate_en = st_gate_open(w_nxt);
    w_en_ack  = (w_nxt == ST_ON);
    w_busy    = st_busy(w_nxt);
    // Sticky through FAULT and the following OFF; cleared only by a fresh power-up.
    w_err     = (w_nxt == ST_FAULT) || (r_err && (w_nxt != ST_PWRUP));
  end

  // State and output registers; reset drops gate and power together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_OFF;
      r_pwr_en  <= 1'b0;
      r_gate_en <= 1'b0;
      r_en_ack  <= 1'b0;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_nxt;
      r_pwr_en  <= w_pwr_en;
      r_gate_en <= w_gate_en;
      r_en_ack  <= w_en_ack;
      r_busy    <= w_busy;
      r_err     <= w_err;
    end
  end

  assign clkbuf_pwr_en  = r_pwr_en;
  assign clkbuf_gate_en = r_gate_en;
  assign en_ack         = r_en_ack;
  assign busy           = r_busy;
  assign err            = r_err;
  assign state_o        = r_state;

endmodule
